iopmp_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream IOPMP check port between `NUM_REQ` requesters (for example, several bus initiators feeding a single rule-check pipeline). The winner is chosen combinationally with two `lzc` instances in trailing-zero mode: one over the rotated (masked) request vector and one over the raw request vector. A registered priority pointer gives fairness, and a registered lock holds a stalled grant stable. Both sides use a valid/ready-style handshake: `req` and `gnt`.

---
 rtl/iopmp_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_iopmp_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iopmp_rr_arbiter.sv
// Round-robin arbiter sharing one IOPMP check port between NUM_REQ requesters.
// A registered priority pointer rotates fairness, a registered lock keeps a
// stalled grant on the same requester until the downstream accepts it.

// Trailing-zero counter: index of the lowest set bit, plus an empty flag.
module iopmp_rr_lzc #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Scan from the top so the lowest set bit is the last one to assign.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        cnt_o = CNT_WIDTH'(i);
      end
    end
    empty_o = ~|in_i;
  end

endmodule

module iopmp_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic                                 req_o,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic [IDX_WIDTH-1:0]                 idx_o,
  input  logic                                 gnt_i
);

  logic [IDX_WIDTH-1:0] rr_reg, rr_next;
  logic                 lock_reg, lock_next;
  logic [IDX_WIDTH-1:0] lock_idx_reg, lock_idx_next;

  logic [IDX_WIDTH-1:0] arb_idx;     // unlocked winner
  logic                 arb_valid;   // any request present
  logic [IDX_WIDTH-1:0] win_idx;     // effective winner (lock-aware)
  logic                 req_sel;     // downstream request
  logic [IDX_WIDTH-1:0] out_idx;
  logic                 fire;

  if (NUM_REQ > 1) begin : g_multi
    logic [NUM_REQ-1:0]   prio_mask;
    logic [NUM_REQ-1:0]   masked_req;
    logic [IDX_WIDTH-1:0] masked_idx, raw_idx;
    logic                 masked_empty, raw_empty;

    // Requesters at or above the pointer get first pick this cycle.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign prio_mask[gi] = (IDX_WIDTH'(gi) >= rr_reg);
    end
    assign masked_req = req_i & prio_mask;

    iopmp_rr_lzc #(.WIDTH(NUM_REQ), .CNT_WIDTH(IDX_WIDTH)) u_lzc_masked (
      .in_i    (masked_req),
      .cnt_o   (masked_idx),
      .empty_o (masked_empty)
    );

    iopmp_rr_lzc #(.WIDTH(NUM_REQ), .CNT_WIDTH(IDX_WIDTH)) u_lzc_raw (
      .in_i    (req_i),
      .cnt_o   (raw_idx),
      .empty_o (raw_empty)
    );

    // Nothing above the pointer: wrap around to the lowest raw requester.
    assign arb_idx   = masked_empty ? raw_idx : masked_idx;
    assign arb_valid = ~raw_empty;
  end else begin : g_single
    assign arb_idx   = '0;
    assign arb_valid = req_i[0];
  end

  // Winner selection: a held lock overrides the round-robin choice.
  always_comb begin
    win_idx = arb_idx;
    req_sel = arb_valid;
    if (lock_reg) begin
      win_idx = lock_idx_reg;
      req_sel = req_i[lock_idx_reg];
    end
  end

  assign fire    = req_sel & gnt_i;
  assign out_idx = req_sel ? win_idx : '0;
  assign idx_o   = out_idx;
  assign req_o   = req_sel;
  assign data_o  = data_i[out_idx];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
    assign gnt_o[gi] = fire & (win_idx == IDX_WIDTH'(gi));
  end

  // Pointer and lock update: flush first, then handshake, stall, or release.
  always_comb begin
    rr_next       = rr_reg;
    lock_next     = lock_reg;
    lock_idx_next = lock_idx_reg;
    if (flush_i) begin
      rr_next       = '0;
      lock_next     = 1'b0;
      lock_idx_next = '0;
    end else if (fire) begin
      rr_next   = (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + IDX_WIDTH'(1);
      lock_next = 1'b0;
    end else if (req_sel) begin
      if (!lock_reg) begin
        lock_next     = 1'b1;
        lock_idx_next = win_idx;
      end
    end else begin
      // Idle, or the locked requester dropped out: nothing left to hold.
      lock_next = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_reg       <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      rr_reg       <= rr_next;
      lock_reg     <= lock_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_reg |-> req_i[lock_idx_reg]);
  a_lock_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_reg && $past(lock_reg)) |-> $stable(data_i[lock_idx_reg]));
  a_idle_no_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !req_o |-> (gnt_o == '0));
`endif

endmodule

// File: tb/tb_iopmp_rr_arbiter.sv
// Randomized and directed bench for iopmp_rr_arbiter against a circular-search
// reference model of the round-robin rules.
module tb_iopmp_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int IW      = 2;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ-1:0][DW-1:0] data_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     req_o;
  logic [DW-1:0]            data_o;
  logic [IW-1:0]            idx_o;
  logic                     gnt_i;

  iopmp_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .req_o   (req_o),
    .data_o  (data_o),
    .idx_o   (idx_o),
    .gnt_i   (gnt_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: pointer, lock flag, locked requester.
  int m_ptr      = 0;
  bit m_locked   = 1'b0;
  int m_lock_idx = 0;

  // Optional directed expectations for the next cycle (-1 = none).
  int want_idx = -1;
  int want_gnt = -1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // First requester found walking circularly upward from the pointer.
  function automatic int find_winner(input logic [NUM_REQ-1:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (m_ptr + k) % NUM_REQ;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  // Apply inputs; the locked requester's payload is kept stable.
  task automatic drive(input logic [NUM_REQ-1:0] r, input bit g, input bit f);
    req_i   = r;
    gnt_i   = g;
    flush_i = f;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!(m_locked && i == m_lock_idx)) data_i[i] = $urandom;
    end
  endtask

  // Check outputs mid-cycle, then advance the model on the clock edge.
  task automatic run_cycle();
    int  win, e_idx;
    bit  e_req;
    logic [NUM_REQ-1:0] e_gnt;
    @(negedge clk_i);
    if (m_locked) begin
      win   = m_lock_idx;
      e_req = req_i[m_lock_idx];
    end else begin
      win   = find_winner(req_i);
      e_req = |req_i;
    end
    e_idx = e_req ? win : 0;
    e_gnt = (e_req && gnt_i) ? NUM_REQ'(1 << win) : '0;
    check_eq("req_o",  64'(req_o),  64'(e_req));
    check_eq("idx_o",  64'(idx_o),  64'(e_idx));
    check_eq("gnt_o",  64'(gnt_o),  64'(e_gnt));
    check_eq("data_o", 64'(data_o), 64'(data_i[e_idx]));
    if (want_idx >= 0) check_eq("dir_idx", 64'(idx_o), 64'(want_idx));
    if (want_gnt >= 0) check_eq("dir_gnt", 64'(gnt_o), 64'(want_gnt));
    want_idx = -1;
    want_gnt = -1;
    $display("cyc %0d rst_n=%b req=%b gnt_i=%b flush=%b -> req_o=%b idx=%0d gnt_o=%b",
             cyc, rst_ni, req_i, gnt_i, flush_i, req_o, idx_o, gnt_o);
    @(posedge clk_i);
    if (rst_ni) begin
      if (flush_i) begin
        m_ptr      = 0;
        m_locked   = 1'b0;
        m_lock_idx = 0;
      end else if (e_req && gnt_i) begin
        m_ptr    = (win + 1) % NUM_REQ;
        m_locked = 1'b0;
      end else if (e_req) begin
        if (!m_locked) begin
          m_locked   = 1'b1;
          m_lock_idx = win;
        end
      end else begin
        m_locked = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] r;
    bit g, f;

    // Reset and idle
    rst_ni = 1'b0;
    drive('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    want_idx = 0; want_gnt = 0;
    run_cycle();
    rst_ni = 1'b1;
    want_idx = 0; want_gnt = 0;
    run_cycle();

    // Full rotation with everyone requesting
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b1, 1'b0);
      want_idx = i % NUM_REQ;
      want_gnt = 1 << (i % NUM_REQ);
      run_cycle();
    end

    // Wrap-around skip: move pointer to 3, then 0101 -> 0, then 2
    drive(4'b0100, 1'b1, 1'b0); want_idx = 2; run_cycle();
    drive(4'b0101, 1'b1, 1'b0); want_idx = 0; run_cycle();
    drive(4'b0101, 1'b1, 1'b0); want_idx = 2; run_cycle();

    // Stall lock on requester 1, then release and check pointer moved to 2
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 1'b0, 1'b0); want_idx = 1; want_gnt = 0; run_cycle();
    end
    drive(4'b0011, 1'b0, 1'b0); want_idx = 1; want_gnt = 0; run_cycle();
    drive(4'b0011, 1'b1, 1'b0); want_idx = 1; want_gnt = 2; run_cycle();
    drive(4'b0011, 1'b1, 1'b0); want_idx = 0; want_gnt = 1; run_cycle();

    // Flush mid-lock: pointer 3, lock on 2, flush, then 1100 -> 2 then 3
    drive(4'b0100, 1'b1, 1'b0); want_idx = 2; run_cycle();
    drive(4'b0100, 1'b0, 1'b0); want_idx = 2; run_cycle();
    drive(4'b0100, 1'b0, 1'b1); want_idx = 2; run_cycle();
    drive(4'b1100, 1'b1, 1'b0); want_idx = 2; want_gnt = 4; run_cycle();
    drive(4'b1100, 1'b1, 1'b0); want_idx = 3; want_gnt = 8; run_cycle();

    // Asynchronous reset while pointer 2 and locked on 2
    drive(4'b0010, 1'b1, 1'b0); want_idx = 1; run_cycle();
    drive(4'b0100, 1'b0, 1'b0); want_idx = 2; run_cycle();
    drive(4'b1111, 1'b1, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    check_eq("arst_idx", 64'(idx_o), 64'd0);
    check_eq("arst_req", 64'(req_o), 64'd1);
    check_eq("arst_gnt", 64'(gnt_o), 64'd1);
    m_ptr = 0; m_locked = 1'b0; m_lock_idx = 0;
    #1 rst_ni = 1'b1;
    want_idx = 0; want_gnt = 1;
    run_cycle();

    // Randomized traffic obeying the lock protocol
    for (int n = 0; n < 300; n++) begin
      r = NUM_REQ'($urandom_range(0, 15));
      if (m_locked) r[m_lock_idx] = 1'b1;
      g = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 19) == 0);
      drive(r, g, f);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
